// File: rtl/clock_mode_ctrl_if.sv
// Control inputs and mode/tick outputs of the mm:ss clock mode controller.
// There is no valid/ready handshake: inputs are raw asynchronous levels, outputs are registered levels/pulses.
interface clock_mode_ctrl_if;
  logic       btn_pause;
  logic       sw_adj;
  logic       sw_sel;
  logic       tick_active;
  logic       count_enable;
  logic       use_2hz;
  logic       sel_minutes;
  logic       sel_seconds;
  logic       blink;
  logic       paused;
  logic [1:0] state_dbg;

  modport master (
    output btn_pause, sw_adj, sw_sel,
    input  tick_active, count_enable, use_2hz, sel_minutes, sel_seconds, blink, paused, state_dbg
  );

  modport slave (
    input  btn_pause, sw_adj, sw_sel,
    output tick_active, count_enable, use_2hz, sel_minutes, sel_seconds, blink, paused, state_dbg
  );
endinterface

// File: rtl/clock_mode_ctrl.sv
// Mode controller and tick scheduler for the mm:ss counter: input sync and debounce,
// RUN/PAUSED/ADJUST state machine, and 1 Hz / 2 Hz single-cycle tick generation.
module clock_mode_ctrl #(
  parameter int DIV_1HZ    = 100000000,
  parameter int DEB_CYCLES = 1000000
) (
  input logic              clk,
  input logic              rst,
  clock_mode_ctrl_if.slave bus
);
  localparam int HALF_DIV = DIV_1HZ / 2;
  localparam int DIV_W    = $clog2(HALF_DIV);
  localparam int DEB_W    = $clog2(DEB_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PAUSED  = 2'd1,
    ADJ_MIN = 2'd2,
    ADJ_SEC = 2'd3
  } state_t;

  logic [1:0]       pause_sync, adj_sync, sel_sync;
  logic             pause_s, adj_s, sel_s;
  logic [DEB_W-1:0] deb_cnt;
  logic             deb_level, press;
  logic [DIV_W-1:0] div_cnt;
  logic             wrap, tick_2hz, tick_1hz, phase, blink_q;
  state_t           state_q, state_d;
  logic             run_q, run_d;
  logic             count_enable_q, use_2hz_q, sel_minutes_q, sel_seconds_q, paused_q;

  assign pause_s = pause_sync[1];
  assign adj_s   = adj_sync[1];
  assign sel_s   = sel_sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      pause_sync <= '0;
      adj_sync   <= '0;
      sel_sync   <= '0;
    end else begin
      pause_sync <= {pause_sync[0], bus.btn_pause};
      adj_sync   <= {adj_sync[0], bus.sw_adj};
      sel_sync   <= {sel_sync[0], bus.sw_sel};
    end
  end

  // The debounced level only moves after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt   <= '0;
      deb_level <= 1'b0;
      press     <= 1'b0;
    end else begin
      press <= 1'b0;
      if (pause_s == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
        deb_cnt   <= '0;
        deb_level <= pause_s;
        press     <= pause_s;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  assign wrap = (div_cnt == DIV_W'(HALF_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      tick_2hz <= 1'b0;
      phase    <= 1'b0;
      blink_q  <= 1'b0;
    end else begin
      div_cnt  <= wrap ? '0 : div_cnt + DIV_W'(1);
      tick_2hz <= wrap;
      blink_q  <= blink_q ^ wrap;
      phase    <= phase ^ tick_2hz;
    end
  end

  // Every second 2 Hz pulse is a 1 Hz pulse: the one seen while phase is still 1.
  assign tick_1hz = tick_2hz & phase;

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    unique case (state_q)
      RUN, PAUSED: begin
        if (adj_s) begin
          state_d = sel_s ? ADJ_SEC : ADJ_MIN;
        end else if (press) begin
          state_d = (state_q == RUN) ? PAUSED : RUN;
          run_d   = (state_q == PAUSED);
        end
      end
      ADJ_MIN, ADJ_SEC: begin
        if (adj_s) state_d = sel_s ? ADJ_SEC : ADJ_MIN;
        else       state_d = run_q ? RUN : PAUSED;
      end
      default: state_d = RUN;
    endcase
  end

  // Mode outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      run_q          <= 1'b1;
      count_enable_q <= 1'b1;
      use_2hz_q      <= 1'b0;
      sel_minutes_q  <= 1'b0;
      sel_seconds_q  <= 1'b0;
      paused_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      run_q          <= run_d;
      count_enable_q <= (state_d == RUN);
      use_2hz_q      <= (state_d == ADJ_MIN) || (state_d == ADJ_SEC);
      sel_minutes_q  <= (state_d == ADJ_MIN);
      sel_seconds_q  <= (state_d == ADJ_SEC);
      paused_q       <= ~run_d;
    end
  end

  assign bus.tick_active  = use_2hz_q ? tick_2hz : tick_1hz;
  assign bus.count_enable = count_enable_q;
  assign bus.use_2hz      = use_2hz_q;
  assign bus.sel_minutes  = sel_minutes_q;
  assign bus.sel_seconds  = sel_seconds_q;
  assign bus.blink        = blink_q;
  assign bus.paused       = paused_q;
  assign bus.state_dbg    = state_q;
endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Bench for clock_mode_ctrl with DIV_1HZ=8, DEB_CYCLES=3: directed stimulus pushes expected
// mode changes, tick/blink times and snapshots into queues; a monitor pops and compares.
module tb_clock_mode_ctrl;
  localparam int DIV = 8;
  localparam int DEB = 3;
  localparam int W   = 37;
  localparam int SW  = 39;

  localparam logic [4:0] V_RUN = 5'b10000;
  localparam logic [4:0] V_PAU = 5'b00001;
  localparam logic [4:0] V_AMR = 5'b01100;
  localparam logic [4:0] V_AMP = 5'b01101;
  localparam logic [4:0] V_ASR = 5'b01010;

  logic clk = 1'b0;
  logic rst = 1'b1;

  clock_mode_ctrl_if bus();

  clock_mode_ctrl #(.DIV_1HZ(DIV), .DEB_CYCLES(DEB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0]  exp_q[$];
  logic [SW-1:0] snap_q[$];
  logic [31:0]   tick_q[$];
  logic [31:0]   blink_q[$];

  bit mon_en   = 1'b0;
  bit tick_en  = 1'b0;
  bit blink_en = 1'b0;
  bit done     = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic exp_mode(input int cycle, input logic [4:0] vec);
    exp_q.push_back({32'(cycle), vec});
  endtask

  task automatic push_snap(input int cycle, input logic [6:0] vec);
    snap_q.push_back({32'(cycle), vec});
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
  endtask

  // Monitor: compares whenever the DUT presents a mode change, tick or blink edge.
  initial begin : monitor
    logic [4:0]    mode_now, prev_mode;
    logic          prev_blink, prev_tick, prev_tick_en, prev_blink_en;
    logic [W-1:0]  e;
    logic [SW-1:0] s;
    logic [31:0]   t;
    prev_mode = '0; prev_blink = 1'b0; prev_tick = 1'b0;
    prev_tick_en = 1'b0; prev_blink_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      mode_now = {bus.count_enable, bus.use_2hz, bus.sel_minutes, bus.sel_seconds, bus.paused};
      if (mon_en) begin
        check("invariants", {bus.sel_minutes & bus.sel_seconds, bus.count_enable & bus.use_2hz,
                             bus.tick_active & prev_tick}, 64'd0);
        if (mode_now !== prev_mode) begin
          if (exp_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL mode_unexpected at cycle %0d: got %b, expected no change from %b",
                     cyc, mode_now, prev_mode);
          end else begin
            e = exp_q.pop_front();
            check("mode_cycle", 64'(cyc), 64'(e[W-1:5]));
            check("mode_value", 64'(mode_now), 64'(e[4:0]));
          end
        end
        if (tick_en && bus.tick_active) begin
          if (tick_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL tick_unexpected at cycle %0d: got tick, expected none", cyc);
          end else begin
            t = tick_q.pop_front();
            check("tick_cycle", 64'(cyc), 64'(t));
          end
        end
        if (prev_tick_en && !tick_en) begin
          check("tick_missing", 64'(tick_q.size()), 64'd0);
          tick_q.delete();
        end
        if (blink_en && (bus.blink !== prev_blink)) begin
          if (blink_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL blink_unexpected at cycle %0d: got toggle, expected none", cyc);
          end else begin
            t = blink_q.pop_front();
            check("blink_cycle", 64'(cyc), 64'(t));
          end
        end
        if (prev_blink_en && !blink_en) begin
          check("blink_missing", 64'(blink_q.size()), 64'd0);
          blink_q.delete();
        end
        while (snap_q.size() > 0 && snap_q[0][SW-1:7] == 32'(cyc)) begin
          s = snap_q.pop_front();
          check("snapshot", 64'({mode_now, bus.blink, bus.tick_active}), 64'(s[6:0]));
        end
        if (done) begin
          check("mode_queue_empty", 64'(exp_q.size()), 64'd0);
          check("snap_queue_empty", 64'(snap_q.size()), 64'd0);
          summary();
          $finish;
        end
      end
      prev_mode     = mode_now;
      prev_blink    = bus.blink;
      prev_tick     = bus.tick_active;
      prev_tick_en  = tick_en;
      prev_blink_en = blink_en;
      if (cyc > 3000) begin
        vectors++; miscompares++;
        $display("FAIL watchdog at cycle %0d: got no end of test, expected done by 3000", cyc);
        summary();
        $finish;
      end
    end
  end

  // Stimulus: all inputs change on the falling edge; c is the edge count at that moment.
  initial begin : stimulus
    int c, r0, t;
    bus.btn_pause = 1'b0;
    bus.sw_adj    = 1'b0;
    bus.sw_sel    = 1'b0;
    idle(3);

    // Reset release and idle: 1 Hz ticks every 8 edges, blink every 4.
    rst = 1'b0;
    r0  = cyc;
    push_snap(r0 + 1, {V_RUN, 1'b0, 1'b0});
    for (int k = 1; k <= 4; k++) tick_q.push_back(32'(r0 + 8 * k));
    for (int k = 1; k <= 9; k++) blink_q.push_back(32'(r0 + 4 * k));
    mon_en = 1'b1; tick_en = 1'b1; blink_en = 1'b1;
    idle(36);
    tick_en = 1'b0; blink_en = 1'b0;
    idle(2);

    // Clean press: 2 sync + 3 debounce + 1 edges to PAUSED, then back to RUN.
    c = cyc; exp_mode(c + 6, V_PAU);
    bus.btn_pause = 1'b1; idle(10); bus.btn_pause = 1'b0; idle(10);
    c = cyc; exp_mode(c + 6, V_RUN);
    bus.btn_pause = 1'b1; idle(10); bus.btn_pause = 1'b0; idle(10);

    // Bounce 1-0-1-0 every 2 cycles, then held: one press 14 edges after the first rise.
    c = cyc; exp_mode(c + 14, V_PAU);
    repeat (2) begin
      bus.btn_pause = 1'b1; idle(2);
      bus.btn_pause = 1'b0; idle(2);
    end
    bus.btn_pause = 1'b1; idle(12); bus.btn_pause = 1'b0; idle(10);

    // From PAUSED: adjust entry coincides with a press (press dropped), another press ignored.
    c = cyc; exp_mode(c + 6, V_AMP);
    bus.btn_pause = 1'b1; idle(3);
    bus.sw_sel = 1'b0; bus.sw_adj = 1'b1; idle(7);
    bus.btn_pause = 1'b0; idle(10);
    bus.btn_pause = 1'b1; idle(10); bus.btn_pause = 1'b0; idle(10);
    c = cyc; exp_mode(c + 3, V_PAU);
    bus.sw_adj = 1'b0; idle(8);

    c = cyc; exp_mode(c + 6, V_RUN);
    bus.btn_pause = 1'b1; idle(10); bus.btn_pause = 1'b0; idle(10);

    // From RUN into ADJ_MIN: 2 Hz ticks on multiples of 4 edges from reset release.
    c = cyc; exp_mode(c + 3, V_AMR);
    bus.sw_sel = 1'b0; bus.sw_adj = 1'b1;
    idle(4);
    t = r0 + 4 * ((cyc - r0) / 4 + 1);
    for (int k = 0; k < 3; k++) tick_q.push_back(32'(t + 4 * k));
    tick_en = 1'b1;
    idle(t + 8 - cyc);
    tick_en = 1'b0;

    // Live field switch to seconds.
    c = cyc; exp_mode(c + 3, V_ASR);
    bus.sw_sel = 1'b1; idle(6);

    // Reset while in ADJ_SEC with the divider mid-count.
    c = cyc; exp_mode(c + 1, V_RUN);
    rst = 1'b1; bus.sw_adj = 1'b0; bus.sw_sel = 1'b0;
    idle(1);
    rst = 1'b0;
    r0  = cyc;
    push_snap(r0 + 1, {V_RUN, 1'b0, 1'b0});
    tick_q.push_back(32'(r0 + 8));
    tick_q.push_back(32'(r0 + 16));
    tick_en = 1'b1;
    idle(16);
    tick_en = 1'b0;
    idle(2);
    done = 1'b1;
  end
endmodule
